// File: rtl/ula_control_fsm_pkg.sv
// Shared encodings for the LASD multicycle control path: states, opcodes, functs,
// ULA op codes and the per-state Moore control word.
package ula_control_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, ALUWB, EXEC_I, IWB, BRANCH, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [2:0] ulactl;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

  function automatic ctrl_t ctrl_for_state(input state_t s, input logic [2:0] rcode);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.memread = 1'b1; c.srcb = SRCB_ONE; end
      DECODE: c.srcb = SRCB_IMM;
      MEMADR: begin c.srca = 1'b1; c.srcb = SRCB_IMM; end
      MEMRD:  begin c.iord = 1'b1; c.memread = 1'b1; end
      MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
      MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      EXEC_R: begin c.srca = 1'b1; c.srcb = SRCB_REG; c.ulactl = rcode; end
      ALUWB:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      EXEC_I: begin c.srca = 1'b1; c.srcb = SRCB_IMM; end
      IWB:    c.regwrite = 1'b1;
      BRANCH: begin c.srca = 1'b1; c.ulactl = ULA_SUB; c.pcsrc = PCSRC_ULAOUT; end
      JUMP:   begin c.pcsrc = PCSRC_JUMP; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ula_control_fsm_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in, ULA code,
// selects and strobes out.
interface ula_control_fsm_if;
  import ula_control_pkg::*;

  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Z;
  logic       MemReady;
  logic [2:0] ULAControl;
  logic       ULASrcA;
  logic [1:0] ULASrcB;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       Illegal;

  modport master (
    input  Opcode, Funct, Z, MemReady,
    output ULAControl, ULASrcA, ULASrcB, PCWrite, PCSrc, IorD,
           MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Illegal
  );

  modport slave (
    output Opcode, Funct, Z, MemReady,
    input  ULAControl, ULASrcA, ULASrcB, PCWrite, PCSrc, IorD,
           MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Illegal
  );
endinterface

// File: rtl/ula_control_fsm_decoder.sv
// R-type funct to ULA op decode, combinational; valid low for unsupported functs.
// No state, no latency, no backpressure.
module ula_decoder
  import ula_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] code,
  output logic       valid
);

  always_comb begin
    code  = ULA_ADD;
    valid = 1'b1;
    case (funct)
      FN_ADD:  code = ULA_ADD;
      FN_SUB:  code = ULA_SUB;
      FN_AND:  code = ULA_AND;
      FN_OR:   code = ULA_OR;
      FN_XOR:  code = ULA_XOR;
      FN_SLT:  code = ULA_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ula_control_fsm.sv
// Multicycle control FSM: 3..5 cycles per instruction; MemReady low in FETCH/MEMRD/MEMWR
// stalls one cycle each. Optional bne support under ULA_CONTROL_FSM_BNE_EN.
module ula_control_fsm
  import ula_control_pkg::*;
(
  input logic                clk,
  input logic                rst,
  ula_control_fsm_if.master  bus
);

  state_t     state;
  state_t     nxt;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl;
  logic [2:0] dec_code;
  logic       dec_ok;
  logic       legal;
  logic       fetch_go;
  logic       take_branch;

  ula_decoder u_dec (
    .funct (bus.Funct),
    .code  (dec_code),
    .valid (dec_ok)
  );

  always_comb begin
    nxt   = state;
    legal = 1'b1;
    case (state)
      FETCH:  if (bus.MemReady) nxt = DECODE;
      DECODE: begin
        case (bus.Opcode)
          OP_RTYPE: begin
            if (dec_ok) nxt = EXEC_R;
            else begin legal = 1'b0; nxt = FETCH; end
          end
          OP_LW, OP_SW: nxt = MEMADR;
          OP_ADDI:      nxt = EXEC_I;
          OP_BEQ:       nxt = BRANCH;
`ifdef ULA_CONTROL_FSM_BNE_EN
          OP_BNE:       nxt = BRANCH;
`endif
          OP_J:         nxt = JUMP;
          default: begin legal = 1'b0; nxt = FETCH; end
        endcase
      end
      MEMADR: nxt = (bus.Opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.MemReady) nxt = MEMWB;
      MEMWR:  if (bus.MemReady) nxt = FETCH;
      EXEC_R: nxt = ALUWB;
      EXEC_I: nxt = IWB;
      default: nxt = FETCH;
    endcase
  end

  // Control word is registered for the state being entered, so it is Moore.
`ifdef ULA_CONTROL_FSM_BNE_EN
  logic bne_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      ctrl_q <= ctrl_for_state(FETCH, ULA_ADD);
      bne_q  <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_for_state(nxt, dec_code);
      if (state == DECODE) bne_q <= (bus.Opcode == OP_BNE);
    end
  end

  assign take_branch = bne_q ? ~bus.Z : bus.Z;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      ctrl_q <= ctrl_for_state(FETCH, ULA_ADD);
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_for_state(nxt, dec_code);
    end
  end

  assign take_branch = bus.Z;
`endif

  assign fetch_go = (state == FETCH) && bus.MemReady;

  always_comb begin
    ctrl = ctrl_q;
    if (state == FETCH) ctrl.memread = bus.MemReady;
    if (state == BRANCH) ctrl.pcwrite = take_branch;
    if (fetch_go) ctrl.pcwrite = 1'b1;
    if (rst) ctrl = '0;
  end

  assign bus.ULAControl = ctrl.ulactl;
  assign bus.ULASrcA    = ctrl.srca;
  assign bus.ULASrcB    = ctrl.srcb;
  assign bus.PCWrite    = ctrl.pcwrite;
  assign bus.PCSrc      = ctrl.pcsrc;
  assign bus.IorD       = ctrl.iord;
  assign bus.MemRead    = ctrl.memread;
  assign bus.MemWrite   = ctrl.memwrite;
  assign bus.RegWrite   = ctrl.regwrite;
  assign bus.RegDst     = ctrl.regdst;
  assign bus.MemtoReg   = ctrl.memtoreg;
  assign bus.IRWrite    = fetch_go && !rst;
  assign bus.Illegal    = !legal && !rst;

endmodule
